// File: rtl/a1csa_pkg.sv
// Shared definitions for the speculative carry-select adder with recovery.
// Holds default geometry, the controller state encoding and the width of
// the recovery counter so the top and the bench agree on them.
package a1csa_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLK   = 4;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    RECOV = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/a1csa_blk.sv
// One carry-select block: adds two BLK-bit slices with a supplied carry-in
// and also reports the block's generate (carry-out assuming carry-in 0)
// and propagate (every bit position propagates) terms.
module a1csa_blk #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] sum,
  output logic           co,
  output logic           g,
  output logic           p
);

  logic [BLK:0] raw;
  logic [BLK:0] full;

  // Raw sum without carry-in gives the generate term; adding ci gives the real block result.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b};
    full = raw + {{BLK{1'b0}}, ci};
  end

  assign sum = full[BLK-1:0];
  assign co  = full[BLK];
  assign g   = raw[BLK];
  assign p   = &(a ^ b);

endmodule

// File: rtl/a1csa_recover.sv
// Speculative carry-select adder with error detection and recovery.
// Each block guesses its carry-in from the previous block's generate term.
// If the guess is right the result leaves one cycle after acceptance; if it
// is wrong the exact sum is delivered a cycle later and flagged.
module a1csa_recover
  import a1csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // WIDTH must be a multiple of BLK with at least two blocks.
  localparam int NB = WIDTH / BLK;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   cin_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [ERR_CNT_W-1:0]   err_cnt_nxt;
  logic                   load;

  logic [WIDTH-1:0]       spec_sum;
  logic [NB-1:0]          blk_co;
  logic [NB-1:0]          g;
  logic [NB-1:0]          p;
  logic [NB-1:0]          spec_ci;
  logic                   spec_err;
  logic [WIDTH:0]         exact_sum;

  // Block 0 sees the true carry-in; every other block guesses from its neighbour's generate.
  assign spec_ci = {g[NB-2:0], cin_q};

  for (genvar k = 0; k < NB; k++) begin : g_blk
    a1csa_blk #(
      .BLK(BLK)
    ) u_blk (
      .a  (a_q[k*BLK +: BLK]),
      .b  (b_q[k*BLK +: BLK]),
      .ci (spec_ci[k]),
      .sum(spec_sum[k*BLK +: BLK]),
      .co (blk_co[k]),
      .g  (g[k]),
      .p  (p[k])
    );
  end

  assign exact_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign err_cnt   = err_cnt_q;

  // Walk the true carry chain, reusing each block's speculative carry-out
  // unless that block itself was mis-speculated; any miss marks an error.
  always_comb begin
    logic carry;
    logic miss;
    carry    = cin_q;
    spec_err = 1'b0;
    miss     = 1'b0;
    for (int k = 0; k < NB; k++) begin
      miss     = (carry != spec_ci[k]);
      spec_err = spec_err | miss;
      carry    = miss ? (g[k] | p[k]) : blk_co[k];
    end
  end

  // Controller next-state and output decode; outputs are zero unless a result is presented.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    sum         = '0;
    cout        = 1'b0;
    err_flag    = 1'b0;
    err_cnt_nxt = err_cnt_q;
    load        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (!spec_err) begin
          out_valid = 1'b1;
          sum       = spec_sum;
          cout      = blk_co[NB-1];
          state_nxt = out_ready ? IDLE : HOLD;
        end else begin
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_nxt = err_cnt_q + ERR_CNT_W'(1);
          end
          state_nxt = RECOV;
        end
      end
      RECOV: begin
        out_valid     = 1'b1;
        {cout, sum}   = exact_sum;
        err_flag      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        sum       = spec_sum;
        cout      = blk_co[NB-1];
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture and recovery counter; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      err_cnt_q <= err_cnt_nxt;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
    end
  end

endmodule

// File: doc/a1csa_recover.md
A1CSA_RECOVER -- requirements
Module: a1csa_recover

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 SHALL have parameter BLK, default 4, meaning carry-select block width; WIDTH SHALL be an integer multiple of BLK, with NB = WIDTH/BLK >= 2.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning operands valid.
REQ-006 SHALL have port in_ready, output, 1, meaning block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH each, meaning the operands.
REQ-008 SHALL have port cin, input, 1, meaning carry-in.
REQ-009 SHALL have port out_valid, output, 1, meaning result valid.
REQ-010 SHALL have port out_ready, input, 1, meaning consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH, meaning the result.
REQ-012 SHALL have port cout, output, 1, meaning carry-out.
REQ-013 SHALL have port err_flag, output, 1, meaning the result came from the recovery path.
REQ-014 SHALL have port err_cnt, output, 16, meaning a saturating count of recoveries.

Function
REQ-015 FSM SHALL have states IDLE, EVAL, RECOV, HOLD.
- in_ready = 1 only in IDLE.
REQ-016 On in_valid && in_ready:
- a, b and cin are registered into a_q, b_q and cin_q.
- Next state is EVAL.
REQ-017 Speculation is computed on a_q/b_q:
- Block k spans bits [k*BLK +: BLK].
- g_k = carry-out of block k with carry-in 0.
- p_k = AND of (a_q^b_q) over block k.
- Speculative carry-in: block 0 uses cin_q; block k>=1 uses g_(k-1).
- spec sum/cout = per-block sums and the top-block carry-out using the speculative carry-ins.
REQ-018 Exact carry-in c_k = exact ripple carry into block k.
- err = OR over k = 1..NB-1 of (c_k != speculative carry-in k).
REQ-019 In EVAL with err = 0:
- out_valid = 1, sum/cout = speculative values, err_flag = 0.
- out_ready = 1 → IDLE; else → HOLD.
REQ-020 In EVAL with err = 1:
- out_valid = 0.
- err_cnt increments by 1, saturating at 0xFFFF.
- Next state is RECOV.
REQ-021 In RECOV:
- out_valid = 1, {cout,sum} = a_q + b_q + cin_q (exact), err_flag = 1.
- out_ready = 1 → IDLE; else remain in RECOV.
REQ-022 In HOLD:
- Outputs equal the EVAL speculative result with err_flag = 0.
- out_ready = 1 → IDLE.
REQ-023 Latency from the acceptance edge at cycle t:
- out_valid is asserted in cycle t+1 when no error.
- out_valid is asserted in cycle t+2 when there is an error.
REQ-024 sum, cout and err_flag SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-025 in_valid is ignored outside IDLE; no operand is lost or overwritten while a result is pending.
REQ-026 When out_valid = 0: sum = 0, cout = 0, err_flag = 0.
REQ-027 A delivered result SHALL always equal the exact (a + b + cin) mod 2^(WIDTH+1).

Reset
REQ-028 When rst_n = 0 at a clock edge:
- State → IDLE.
- a_q, b_q, cin_q → 0.
- err_cnt → 0.
- out_valid, sum, cout, err_flag = 0 in the following cycle.
- in_ready = 1 in the following cycle.
REQ-029 Reset in EVAL, RECOV or HOLD SHALL discard the pending result without emitting it.

Structure
REQ-030 Shared package a1csa_pkg SHALL hold:
- default WIDTH and BLK constants.
- the state-encoding typedef (IDLE, EVAL, RECOV, HOLD).
- the err_cnt width constant (16).
REQ-031 One sub-module, a1csa_blk, SHALL be used, instantiated NB times:
- Inputs: BLK-bit a and b slices, plus carry-in.
- Outputs: BLK-bit sum, carry-out, g, p.

Verification (WIDTH = 8, BLK = 4)
REQ-032 a = 0x0F, b = 0x01, cin = 0 → out_valid at t+1, sum = 0x10, cout = 0, err_flag = 0, err_cnt unchanged.
REQ-033 a = 0x0F, b = 0x00, cin = 1 → out_valid low at t+1; at t+2 sum = 0x10, cout = 0, err_flag = 1, err_cnt += 1.
REQ-034 a = 0xFF, b = 0x00, cin = 1 with out_ready held 0 for 3 cycles → RECOV held, sum = 0x00, cout = 1, err_flag = 1 stable; in_valid pulses during the hold are ignored.
REQ-035 Force err_cnt to 0xFFFE, then two error cases → err_cnt = 0xFFFF, staying 0xFFFF after the second.
REQ-036 rst_n = 0 in the EVAL cycle of an error case → no result emitted; next cycle in_ready = 1 and err_cnt = 0.
REQ-037 Random back-to-back operands with random out_ready, checked against the golden a + b + cin → every delivered result exact, err_flag matching the REQ-018 err prediction.
